rps_match_tracker: RTL and testbench
====================================

# rps_match_tracker

Downstream match controller for the stone-paper-scissors round engine. It consumes one round result per round, keeps per-player scores, round and invalid-round counts, and decides a best-of-N match winner. It also issues a one-cycle `round_req` pulse that the round engine uses as its `start`.

## Interface
Parameters:
- WINS_TO_TAKE, default 2: round wins that end the match (best of 3); legal range 1..15.
- MAX_ROUNDS, default 7: decided rounds (wins plus ties) after which the match ends regardless; range 1..15, at least WINS_TO_TAKE.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- new_match  in  1  one-cycle pulse; starts or restarts a match.
- round_valid  in  1  one-cycle strobe; round_winner is valid this cycle.
- round_winner  in  2  round result: 00 tie, 01 P1, 10 P2, 11 invalid move.
- round_req  out  1  one-cycle pulse requesting the next round.
- p1_score  out  4  P1 round wins this match.
- p2_score  out  4  P2 round wins this match.
- round_count  out  4  decided rounds (P1, P2 or tie) this match.
- invalid_count  out  3  invalid rounds this match; saturates at 7.
- match_over  out  1  high while in DONE.
- match_winner  out  2  00 draw or none, 01 P1, 10 P2; valid when match_over.
- state  out  2  00 IDLE, 01 PLAY, 10 DONE.

## Operation
- Reset values: state IDLE; all counts, scores and match_winner 0; round_req 0; match_over 0.
- IDLE: round_valid is ignored. new_match clears scores and counts, moves to PLAY, and pulses round_req.
- PLAY, round_valid with 01/10: the matching score increments and round_count increments.
- PLAY, round_valid with 00: round_count increments only.
- PLAY, round_valid with 11: invalid_count increments (saturating). Scores and round_count are unchanged. The round is replayed.
- End check uses the post-update values:
  - a score equal to WINS_TO_TAKE means that player wins;
  - otherwise round_count equal to MAX_ROUNDS means the higher score wins, and equal scores give 00.
  - When the check passes, go to DONE, latch match_winner, and suppress round_req.
- If the end check fails after any valid round (including 11), pulse round_req.
- DONE: all outputs hold. round_valid is ignored. new_match behaves as it does from IDLE.
- new_match in PLAY: the match restarts (counts cleared, round_req pulsed). A round_valid in the same cycle is dropped.
- round_winner is sampled only when round_valid is high.
- Counters never wrap. The parameter limits guarantee the 4-bit fields do not overflow.

## Timing
- All outputs are registered. Effects appear one cycle after the sampling edge.
- new_match sampled at edge N gives at edge N+1: state=PLAY, counts=0, round_req=1. round_req is high for exactly one cycle.
- round_valid sampled at edge N gives at edge N+1 the updated score or count plus either round_req=1 or (state=DONE, match_over=1, match_winner set), never both.
- round_req to the next round_valid has unbounded latency. Back-to-back round_valid strobes on consecutive cycles are each processed.
- Asynchronous reset mid-match returns to IDLE immediately, with no round_req.

## Structure
- Shared package rps_pkg holds:
  - move codes (00 stone, 01 paper, 10 scissors, 11 invalid);
  - result codes (RES_TIE, RES_P1, RES_P2, RES_INVALID);
  - state codes (ST_IDLE, ST_PLAY, ST_DONE);
  - match_winner codes.
- One sub-module, rps_score_ctr: a 4-bit counter with clear, increment and saturate. It is instantiated for p1_score, p2_score and round_count; invalid_count uses a 3-bit variant.
- No other hierarchy.

## Test plan
- Reset, then new_match → next cycle state=01, round_req=1 for one cycle, all counts 0.
- With defaults, results 01, 10, 01 → p1=2, p2=1, round_count=3, state=10, match_winner=01, no round_req after the third result.
- 7 ties → round_count=7, scores 0/0, match_over=1, match_winner=00. With WINS_TO_TAKE=3, MAX_ROUNDS=5 and results 01, 01, 10, 10, 00 → match_winner=00.
- Nine 11 results in PLAY → invalid_count=7 (saturated), round_count=0, round_req pulsed after each; a following 10 gives p2=1.
- new_match in the same cycle as round_valid=01 in PLAY → p1=0, round_count=0, round_req=1. round_valid in DONE → no change.
- Reset asserted asynchronously between edges mid-match → outputs 0 and state=00 before the next edge.

Source files
------------

// File: rtl/rps_pkg.sv
// rtl/rps_pkg.sv - shared codes for the stone-paper-scissors round engine and match tracker
package rps_pkg;

    localparam logic [1:0] MV_STONE    = 2'b00;
    localparam logic [1:0] MV_PAPER    = 2'b01;
    localparam logic [1:0] MV_SCISSORS = 2'b10;
    localparam logic [1:0] MV_INVALID  = 2'b11;

    typedef enum logic [1:0] {
        RES_TIE     = 2'b00,
        RES_P1      = 2'b01,
        RES_P2      = 2'b10,
        RES_INVALID = 2'b11
    } result_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        MW_NONE = 2'b00,
        MW_P1   = 2'b01,
        MW_P2   = 2'b10
    } match_winner_t;

endpackage

// File: rtl/rps_score_ctr.sv
// rtl/rps_score_ctr.sv - saturating counter with clear, used for scores and round counts
module rps_score_ctr #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/rps_match_tracker.sv
// rtl/rps_match_tracker.sv - best-of-N match controller fed by per-round results
module rps_match_tracker
    import rps_pkg::*;
#(
    parameter int WINS_TO_TAKE = 2,
    parameter int MAX_ROUNDS   = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       new_match,
    input  logic       round_valid,
    input  logic [1:0] round_winner,
    output logic       round_req,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic [3:0] round_count,
    output logic [2:0] invalid_count,
    output logic       match_over,
    output logic [1:0] match_winner,
    output logic [1:0] state
);

    localparam logic [3:0] L_WINS = 4'(WINS_TO_TAKE);
    localparam logic [3:0] L_MAX  = 4'(MAX_ROUNDS);

    state_t        r_state;
    match_winner_t r_winner;
    logic          r_req;
    logic          r_over;

    logic          w_active;
    logic          w_inc_p1;
    logic          w_inc_p2;
    logic          w_inc_rc;
    logic          w_inc_inv;
    logic [3:0]    w_p1_post;
    logic [3:0]    w_p2_post;
    logic [3:0]    w_rc_post;
    logic          w_end;
    match_winner_t w_winner;

    // A round arriving together with new_match is dropped in favour of the restart.
    assign w_active  = (r_state == ST_PLAY) && round_valid && !new_match;
    assign w_inc_p1  = w_active && (round_winner == RES_P1);
    assign w_inc_p2  = w_active && (round_winner == RES_P2);
    assign w_inc_rc  = w_active && (round_winner != RES_INVALID);
    assign w_inc_inv = w_active && (round_winner == RES_INVALID);

    rps_score_ctr #(.W(4)) u_p1_ctr (
        .clk(clk), .rst(reset), .i_clr(new_match), .i_inc(w_inc_p1), .o_count(p1_score)
    );
    rps_score_ctr #(.W(4)) u_p2_ctr (
        .clk(clk), .rst(reset), .i_clr(new_match), .i_inc(w_inc_p2), .o_count(p2_score)
    );
    rps_score_ctr #(.W(4)) u_rc_ctr (
        .clk(clk), .rst(reset), .i_clr(new_match), .i_inc(w_inc_rc), .o_count(round_count)
    );
    rps_score_ctr #(.W(3)) u_inv_ctr (
        .clk(clk), .rst(reset), .i_clr(new_match), .i_inc(w_inc_inv), .o_count(invalid_count)
    );

    // End check looks at the values the counters will hold after this edge.
    assign w_p1_post = p1_score    + {3'b000, w_inc_p1};
    assign w_p2_post = p2_score    + {3'b000, w_inc_p2};
    assign w_rc_post = round_count + {3'b000, w_inc_rc};
    assign w_end     = (w_p1_post == L_WINS) || (w_p2_post == L_WINS) || (w_rc_post == L_MAX);

    always_comb begin
        w_winner = MW_NONE;
        if (w_p1_post == L_WINS) begin
            w_winner = MW_P1;
        end else if (w_p2_post == L_WINS) begin
            w_winner = MW_P2;
        end else if (w_rc_post == L_MAX) begin
            if (w_p1_post > w_p2_post) begin
                w_winner = MW_P1;
            end else if (w_p2_post > w_p1_post) begin
                w_winner = MW_P2;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_winner <= MW_NONE;
            r_req    <= 1'b0;
            r_over   <= 1'b0;
        end else begin
            r_req <= 1'b0;
            if (new_match) begin
                r_state  <= ST_PLAY;
                r_winner <= MW_NONE;
                r_over   <= 1'b0;
                r_req    <= 1'b1;
            end else if (w_active) begin
                if (w_end) begin
                    r_state  <= ST_DONE;
                    r_winner <= w_winner;
                    r_over   <= 1'b1;
                end else begin
                    r_req <= 1'b1;
                end
            end
        end
    end

    assign round_req    = r_req;
    assign match_over   = r_over;
    assign match_winner = r_winner;
    assign state        = r_state;

endmodule

// File: tb/tb_rps_match_tracker.sv
// tb/tb_rps_match_tracker.sv - directed vector bench for rps_match_tracker
module tb_rps_match_tracker;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       new_match = 1'b0;
    logic       round_valid = 1'b0;
    logic [1:0] round_winner = 2'b00;
    logic       round_req;
    logic [3:0] p1_score, p2_score, round_count;
    logic [2:0] invalid_count;
    logic       match_over;
    logic [1:0] match_winner, state;

    logic       b_new_match = 1'b0;
    logic       b_round_valid = 1'b0;
    logic [1:0] b_round_winner = 2'b00;
    logic       b_round_req;
    logic [3:0] b_p1_score, b_p2_score, b_round_count;
    logic [2:0] b_invalid_count;
    logic       b_match_over;
    logic [1:0] b_match_winner, b_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rps_match_tracker dut (
        .clk(clk), .reset(reset), .new_match(new_match), .round_valid(round_valid),
        .round_winner(round_winner), .round_req(round_req), .p1_score(p1_score),
        .p2_score(p2_score), .round_count(round_count), .invalid_count(invalid_count),
        .match_over(match_over), .match_winner(match_winner), .state(state)
    );

    rps_match_tracker #(.WINS_TO_TAKE(3), .MAX_ROUNDS(5)) dut_b (
        .clk(clk), .reset(reset), .new_match(b_new_match), .round_valid(b_round_valid),
        .round_winner(b_round_winner), .round_req(b_round_req), .p1_score(b_p1_score),
        .p2_score(b_p2_score), .round_count(b_round_count), .invalid_count(b_invalid_count),
        .match_over(b_match_over), .match_winner(b_match_winner), .state(b_state)
    );

    typedef struct {
        logic       nm;
        logic       rv;
        logic [1:0] w;
        logic [3:0] p1;
        logic [3:0] p2;
        logic [3:0] rc;
        logic [2:0] ic;
        logic [1:0] st;
        logic       req;
        logic [1:0] mw;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic nm, input logic rv, input logic [1:0] w,
                                input int p1, input int p2, input int rc, input int ic,
                                input int st, input logic req, input int mw);
        vec_t v;
        v.nm = nm; v.rv = rv; v.w = w;
        v.p1 = 4'(p1); v.p2 = 4'(p2); v.rc = 4'(rc); v.ic = 3'(ic);
        v.st = 2'(st); v.req = req; v.mw = 2'(mw);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_a(input string tag, input vec_t v);
        chk({tag, " p1"}, 32'(p1_score), 32'(v.p1));
        chk({tag, " p2"}, 32'(p2_score), 32'(v.p2));
        chk({tag, " rc"}, 32'(round_count), 32'(v.rc));
        chk({tag, " ic"}, 32'(invalid_count), 32'(v.ic));
        chk({tag, " state"}, 32'(state), 32'(v.st));
        chk({tag, " req"}, 32'(round_req), 32'(v.req));
        chk({tag, " winner"}, 32'(match_winner), 32'(v.mw));
        chk({tag, " over"}, 32'(match_over), (v.st == 2'b10) ? 32'd1 : 32'd0);
    endtask

    task automatic step_a(input logic nm, input logic rv, input logic [1:0] w);
        new_match = nm; round_valid = rv; round_winner = w;
        @(posedge clk);
        #1;
        new_match = 1'b0; round_valid = 1'b0; round_winner = 2'b00;
    endtask

    task automatic step_b(input logic nm, input logic rv, input logic [1:0] w);
        b_new_match = nm; b_round_valid = rv; b_round_winner = w;
        @(posedge clk);
        #1;
        b_new_match = 1'b0; b_round_valid = 1'b0; b_round_winner = 2'b00;
    endtask

    initial begin
        vecs.push_back(mk(1, 0, 2'd0, 0, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 2'd0, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 2'd1, 1, 0, 1, 0, 1, 1, 0));
        vecs.push_back(mk(0, 1, 2'd2, 1, 1, 2, 0, 1, 1, 0));
        vecs.push_back(mk(0, 1, 2'd1, 2, 1, 3, 0, 2, 0, 1));
        vecs.push_back(mk(0, 1, 2'd2, 2, 1, 3, 0, 2, 0, 1));
        vecs.push_back(mk(1, 0, 2'd0, 0, 0, 0, 0, 1, 1, 0));
        for (int k = 1; k <= 6; k++) vecs.push_back(mk(0, 1, 2'd0, 0, 0, k, 0, 1, 1, 0));
        vecs.push_back(mk(0, 1, 2'd0, 0, 0, 7, 0, 2, 0, 0));
        vecs.push_back(mk(1, 0, 2'd0, 0, 0, 0, 0, 1, 1, 0));
        for (int k = 1; k <= 9; k++) vecs.push_back(mk(0, 1, 2'd3, 0, 0, 0, (k > 7) ? 7 : k, 1, 1, 0));
        vecs.push_back(mk(0, 1, 2'd2, 0, 1, 1, 7, 1, 1, 0));
        vecs.push_back(mk(1, 1, 2'd1, 0, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 1, 2'd1, 1, 0, 1, 0, 1, 1, 0));
        vecs.push_back(mk(1, 1, 2'd1, 0, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 1, 2'd1, 1, 0, 1, 0, 1, 1, 0));

        repeat (2) @(posedge clk);
        #1;
        check_a("reset", mk(0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0));
        reset = 1'b0;

        step_a(1'b0, 1'b1, 2'd1);
        check_a("idle_ignore", mk(0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            step_a(vecs[i].nm, vecs[i].rv, vecs[i].w);
            check_a($sformatf("vec%0d", i), vecs[i]);
        end

        // Asynchronous reset lands between edges while P1 holds a point.
        #2 reset = 1'b1;
        #1;
        check_a("async_reset", mk(0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0));
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        check_a("post_reset", mk(0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0));

        step_b(1'b1, 1'b0, 2'd0);
        chk("b start state", 32'(b_state), 32'd1);
        chk("b start req", 32'(b_round_req), 32'd1);
        step_b(1'b0, 1'b1, 2'd1);
        step_b(1'b0, 1'b1, 2'd1);
        chk("b p1 two no win", 32'(b_state), 32'd1);
        chk("b req after 2", 32'(b_round_req), 32'd1);
        step_b(1'b0, 1'b1, 2'd2);
        step_b(1'b0, 1'b1, 2'd2);
        step_b(1'b0, 1'b1, 2'd0);
        chk("b p1", 32'(b_p1_score), 32'd2);
        chk("b p2", 32'(b_p2_score), 32'd2);
        chk("b rc", 32'(b_round_count), 32'd5);
        chk("b state", 32'(b_state), 32'd2);
        chk("b over", 32'(b_match_over), 32'd1);
        chk("b winner", 32'(b_match_winner), 32'd0);
        chk("b req", 32'(b_round_req), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
